// File: rtl/swipt_gate_drive_if.sv
// swipt_gate_drive_if: enable/frequency request in, complementary gate drive and status out
interface swipt_gate_drive_if;
  logic en;
  logic [19:0] freq_in;
  logic gate_hi;
  logic gate_lo;
  logic [19:0] cur_freq;
  logic period_tick;
  logic freq_clamped;
  modport master (
    output en, freq_in,
    input gate_hi, gate_lo, cur_freq, period_tick, freq_clamped
  );
  modport slave (
    input en, freq_in,
    output gate_hi, gate_lo, cur_freq, period_tick, freq_clamped
  );
endinterface

// File: rtl/swipt_gate_drive.sv
// swipt_gate_drive: phase-accumulator half-bridge gate driver with clamped frequency load and fixed dead time
module swipt_gate_drive #(
  parameter int CLK_HZ = 100_000_000,
  parameter int DEAD_CYC = 10,
  parameter logic [19:0] FREQ_MIN = 20'h7530,
  parameter logic [19:0] FREQ_MAX = 20'hC350,
  parameter logic [19:0] FREQ_RST = 20'h88B8
) (
  input logic clk,
  input logic rst,
  swipt_gate_drive_if.slave bus
);
  localparam logic [26:0] CLK_LIM = 27'(CLK_HZ);
  localparam logic [26:0] HALF = 27'(CLK_HZ / 2);
  localparam int CW = $clog2(DEAD_CYC + 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  typedef enum logic [2:0] {OFF, HI, DEAD_HL, LO, DEAD_LH} stateT;
  stateT state;
  logic [26:0] acc;
  logic [26:0] sum;
  logic [26:0] accNext;
  logic [CW-1:0] deadCnt;
  logic wrap;
  logic phNext;
  logic tooLow;
  logic tooHigh;
  logic [19:0] loadFreq;
  // gate decisions use the phase of the accumulator value being registered, so gates line up with ph
  always_comb begin
    sum = acc + {7'd0, bus.cur_freq};
    wrap = sum >= CLK_LIM;
    accNext = wrap ? sum - CLK_LIM : sum;
    phNext = accNext < HALF;
    tooLow = bus.freq_in < FREQ_MIN;
    tooHigh = bus.freq_in > FREQ_MAX;
    loadFreq = tooLow ? FREQ_MIN : tooHigh ? FREQ_MAX : bus.freq_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      acc <= '0;
      deadCnt <= '0;
      bus.gate_hi <= 1'b0;
      bus.gate_lo <= 1'b0;
      bus.period_tick <= 1'b0;
      bus.cur_freq <= FREQ_RST;
      bus.freq_clamped <= 1'b0;
    end else if (!bus.en) begin
      state <= OFF;
      acc <= '0;
      bus.gate_hi <= 1'b0;
      bus.gate_lo <= 1'b0;
      bus.period_tick <= 1'b0;
    end else if (state == OFF) begin
      state <= HI;
      bus.gate_hi <= 1'b1;
      bus.gate_lo <= 1'b0;
      bus.cur_freq <= loadFreq;
      bus.freq_clamped <= tooLow | tooHigh;
    end else begin
      acc <= accNext;
      bus.period_tick <= wrap;
      if (wrap) begin
        bus.cur_freq <= loadFreq;
        bus.freq_clamped <= tooLow | tooHigh;
      end
      case (state)
        HI: if (!phNext) begin
          state <= DEAD_HL;
          bus.gate_hi <= 1'b0;
          deadCnt <= '0;
        end
        LO: if (phNext) begin
          state <= DEAD_LH;
          bus.gate_lo <= 1'b0;
          deadCnt <= '0;
        end
        default: if (deadCnt == DEAD_LAST) begin
          state <= phNext ? HI : LO;
          bus.gate_hi <= phNext;
          bus.gate_lo <= !phNext;
        end else begin
          deadCnt <= deadCnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: doc/swipt_gate_drive.md
SWIPT_GATE_DRIVE -- requirements
Module: swipt_gate_drive

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock rate in Hz.
REQ-002 SHALL have parameter DEAD_CYC, default 10, dead-time length in clock cycles.
REQ-003 SHALL have parameter FREQ_MIN, default 20'h7530 (30 kHz), lowest permitted drive frequency.
REQ-004 SHALL have parameter FREQ_MAX, default 20'hC350 (50 kHz), highest permitted drive frequency.
REQ-005 SHALL have parameter FREQ_RST, default 20'h88B8 (35 kHz), frequency loaded at reset.
REQ-006 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port en  input  1  drive enable (SWIPT link alive).
REQ-009 SHALL have port freq_in  input  20  requested drive frequency in Hz (newFreq from the frequency-search stage).
REQ-010 SHALL have port gate_hi  output  1  high-side gate drive.
REQ-011 SHALL have port gate_lo  output  1  low-side gate drive.
REQ-012 SHALL have port cur_freq  output  20  frequency currently being generated.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse at each period wrap.
REQ-014 SHALL have port freq_clamped  output  1  high when the last loaded freq_in was outside [FREQ_MIN, FREQ_MAX].

Function
REQ-015 SHALL keep a 27-bit phase accumulator acc; each running cycle, s = acc + cur_freq; s >= CLK_HZ -> acc <= s - CLK_HZ and period_tick = 1 in the next cycle; otherwise acc <= s.
REQ-016 SHALL derive raw phase ph = (acc < CLK_HZ/2); ph = 1 is the high half-period.
REQ-017 SHALL load cur_freq from freq_in only on the wrap cycle or on the OFF->HI transition; freq_in changes at any other time have no effect until the next wrap.
REQ-018 SHALL clamp on load: freq_in < FREQ_MIN -> FREQ_MIN; freq_in > FREQ_MAX -> FREQ_MAX; freq_clamped is registered with the same load and held until the next load.
REQ-019 SHALL implement FSM states OFF, HI, DEAD_HL, LO, DEAD_LH.
REQ-020 OFF: gates 0, acc held at 0; en = 1 -> HI with a cur_freq load.
REQ-021 HI: gate_hi = 1; ph falls to 0 -> DEAD_HL.
REQ-022 LO: gate_lo = 1; ph rises to 1 -> DEAD_LH.
REQ-023 DEAD_HL and DEAD_LH: both gates 0 for exactly DEAD_CYC cycles, then go to HI if ph = 1 or LO if ph = 0; a ph change during dead time does not shorten or extend it.
REQ-024 SHALL never assert gate_hi and gate_lo in the same cycle, in any state or on any reset or enable path.
REQ-025 en = 0 in any state -> OFF on the next edge, gates 0 on that edge, acc cleared; cur_freq and freq_clamped are retained.
REQ-026 SHALL drive gates from registers (no combinational path from inputs to gates); period_tick is registered.

Reset
REQ-027 rst = 1 on a clock edge SHALL set state OFF, acc 0, gate_hi 0, gate_lo 0, period_tick 0, cur_freq FREQ_RST, freq_clamped 0.
REQ-028 rst SHALL take priority over en; rst asserted mid-period SHALL force gates to 0 on that edge, with no dead-time sequencing.
REQ-029 After rst is released with en = 1, the first HI cycle SHALL occur one cycle later, loading freq_in.

Verification
REQ-030 rst, then en = 1, freq_in = 40000 -> period 2500 cycles; period_tick every 2500 cycles; gate_hi 1240 cycles and gate_lo 1240 cycles per period, each separated by 10-cycle dead gaps (first HI is 1250 cycles).
REQ-031 Running at 40000, freq_in -> 35000 at cycle 500 of a period -> cur_freq stays 40000 until that period's wrap, then 35000; next period is 2858 or 2857 cycles (accumulator residue) and period_tick spacing averages 2857.14 over 7 periods.
REQ-032 freq_in = 20'h00100 loaded -> cur_freq = 20'h7530, freq_clamped = 1; freq_in = 20'hFFFFF -> cur_freq = 20'hC350, freq_clamped = 1; freq_in = 20'h9C40 -> freq_clamped = 0.
REQ-033 en dropped while gate_hi = 1 -> both gates 0 on the next edge, state OFF; en restored -> HI on the following edge, acc restarts at 0.
REQ-034 rst pulsed during DEAD_LH -> gates 0 and cur_freq = 20'h88B8 on that edge; assertion over the full run: gate_hi & gate_lo never 1.
REQ-035 Sweep freq_in across FREQ_MIN to FREQ_MAX in steps of 50 at each period_tick -> each period length = floor or ceil of CLK_HZ / cur_freq; no overlap between gates; dead gaps exactly DEAD_CYC.
